// File: rtl/prim_ram_1p_arb_pkg.sv
// ============================================================================
//  Module   : prim_ram_1p_arb_pkg
//  Purpose  : Shared types and constants for the two-requester single-port
//             RAM arbiter with built-in memory wipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prim_ram_1p_arb_pkg;

    // Arbiter operating mode: wiping the RAM, or arbitrating requesters.
    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } arb_state_e;

    // Number of requesters and their bit positions in request/grant vectors.
    localparam int unsigned NumReq = 2;
    localparam int unsigned ReqA   = 0;
    localparam int unsigned ReqB   = 1;

endpackage : prim_ram_1p_arb_pkg

`default_nettype wire

// File: rtl/prim_ram_1p_arb_rr.sv
// ============================================================================
//  Module   : prim_ram_1p_arb_rr
//  Purpose  : Two-way round-robin arbiter. Grant is combinational; the
//             priority pointer flips to the other requester after each grant
//             and holds when nothing is granted.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_ram_1p_arb_rr
    import prim_ram_1p_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    // High when requester b wins a tie; cleared at reset so a wins first.
    logic prio_b_q;
    logic prio_b_d;

    // Grant: a lone requester always wins; a tie goes to the pointer.
    always_comb begin
        gnt_o = '0;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_b_q ? 2'b10 : 2'b01;
            default: gnt_o = '0;
        endcase
    end

    // Pointer moves away from whoever was just served; idle cycles keep it.
    always_comb begin
        prio_b_d = prio_b_q;
        if (gnt_o[ReqA]) begin
            prio_b_d = 1'b1;
        end else if (gnt_o[ReqB]) begin
            prio_b_d = 1'b0;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule : prim_ram_1p_arb_rr

`default_nettype wire

// File: rtl/prim_ram_1p_arb.sv
// ============================================================================
//  Module   : prim_ram_1p_arb
//  Purpose  : Arbitrates two requesters onto one single-port RAM. After reset
//             (or on request) the whole RAM is wiped to zero, one word per
//             cycle, before arbitration resumes. Reads return one cycle
//             after grant; rvalid is steered to the owner of the read.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_ram_1p_arb
    import prim_ram_1p_arb_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 128,
    localparam int unsigned Aw   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    // Requester a
    input  logic             a_req_i,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_gnt_o,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,

    // Requester b
    input  logic             b_req_i,
    input  logic             b_write_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_gnt_o,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,

    // RAM side
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,

    // Wipe control
    input  logic             init_req_i,
    output logic             init_done_o
);

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [Aw-1:0]     cnt_q;
    logic [Aw-1:0]     cnt_d;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [NumReq-1:0] rr_req;
    logic [NumReq-1:0] rr_gnt;

    // Only Run mode presents requests to the arbiter, so grants (and pointer
    // updates) are impossible while wiping.
    assign rr_req = (state_q == StRun) ? {b_req_i, a_req_i} : '0;

    prim_ram_1p_arb_rr u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (rr_req),
        .gnt_o  (rr_gnt)
    );

    // State and wipe-address registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: wipe walks 0..Depth-1 then runs; a wipe request in Run
    // restarts from address 0, while one arriving mid-wipe is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + Aw'(1);
                end
            end
            StRun: begin
                cnt_d = '0;
                if (init_req_i) begin
                    state_d = StInit;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM port drive: wipe writes in Init, the granted requester in Run.
    // Everything is forced idle while reset is held so the RAM sees no
    // stray access during reset assertion.
    always_comb begin
        ram_req_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wmask_o = '0;
        unique case (state_q)
            StInit: begin
                ram_req_o   = 1'b1;
                ram_write_o = 1'b1;
                ram_addr_o  = cnt_q;
                ram_wdata_o = '0;
                ram_wmask_o = '1;
            end
            StRun: begin
                if (rr_gnt[ReqA]) begin
                    ram_req_o   = 1'b1;
                    ram_write_o = a_write_i;
                    ram_addr_o  = a_addr_i;
                    ram_wdata_o = a_wdata_i;
                    ram_wmask_o = a_wmask_i;
                end else if (rr_gnt[ReqB]) begin
                    ram_req_o   = 1'b1;
                    ram_write_o = b_write_i;
                    ram_addr_o  = b_addr_i;
                    ram_wdata_o = b_wdata_i;
                    ram_wmask_o = b_wmask_i;
                end
            end
            default: begin
                ram_req_o = 1'b0;
            end
        endcase
        if (!rst_ni) begin
            ram_req_o   = 1'b0;
            ram_write_o = 1'b0;
        end
    end

    // Read-return tracking: remember which requester owns the read issued
    // this cycle so its rvalid fires when the RAM data arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            a_rvalid_q <= rr_gnt[ReqA] & ~a_write_i;
            b_rvalid_q <= rr_gnt[ReqB] & ~b_write_i;
        end
    end

    assign a_gnt_o     = rr_gnt[ReqA];
    assign b_gnt_o     = rr_gnt[ReqB];
    assign a_rvalid_o  = a_rvalid_q;
    assign b_rvalid_o  = b_rvalid_q;
    // Read data is shared; only rvalid identifies the owner.
    assign a_rdata_o   = ram_rdata_i;
    assign b_rdata_o   = ram_rdata_i;
    assign init_done_o = (state_q == StRun);

endmodule : prim_ram_1p_arb

`default_nettype wire

// File: tb/tb_prim_ram_1p_arb.sv
// ============================================================================
//  Module   : tb_prim_ram_1p_arb
//  Purpose  : Directed self-checking bench for prim_ram_1p_arb (Depth = 8),
//             with a behavioural single-port RAM behind the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prim_ram_1p_arb;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 8;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_write, b_req, b_write;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, a_wmask, b_wdata, b_wmask;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [W-1:0]  a_rdata, b_rdata;
    logic          ram_req, ram_write;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata, ram_wmask, ram_rdata;
    logic          init_req, init_done;

    int n_checks = 0;
    int n_fail   = 0;

    prim_ram_1p_arb #(.Width(W), .Depth(D)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .a_req_i     (a_req),
        .a_write_i   (a_write),
        .a_addr_i    (a_addr),
        .a_wdata_i   (a_wdata),
        .a_wmask_i   (a_wmask),
        .a_gnt_o     (a_gnt),
        .a_rvalid_o  (a_rvalid),
        .a_rdata_o   (a_rdata),
        .b_req_i     (b_req),
        .b_write_i   (b_write),
        .b_addr_i    (b_addr),
        .b_wdata_i   (b_wdata),
        .b_wmask_i   (b_wmask),
        .b_gnt_o     (b_gnt),
        .b_rvalid_o  (b_rvalid),
        .b_rdata_o   (b_rdata),
        .ram_req_o   (ram_req),
        .ram_write_o (ram_write),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_wmask_o (ram_wmask),
        .ram_rdata_i (ram_rdata),
        .init_req_i  (init_req),
        .init_done_o (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, one-cycle read latency, bit-masked writes.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_write) begin
                mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] addr,
                           input logic [W-1:0] wdata, input logic [W-1:0] wmask);
        a_req = req; a_write = wr; a_addr = addr; a_wdata = wdata; a_wmask = wmask;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] addr,
                           input logic [W-1:0] wdata, input logic [W-1:0] wmask);
        b_req = req; b_write = wr; b_addr = addr; b_wdata = wdata; b_wmask = wmask;
    endtask

    // Expects Init mode at wipe address addr, with requester a asking.
    task automatic check_wipe(input int addr);
        check("wipe_req",   {31'b0, ram_req},   32'h1);
        check("wipe_write", {31'b0, ram_write}, 32'h1);
        check("wipe_addr",  {29'b0, ram_addr},  32'(addr));
        check("wipe_wdata", ram_wdata,          32'h0);
        check("wipe_wmask", ram_wmask,          32'hFFFF_FFFF);
        check("wipe_done",  {31'b0, init_done}, 32'h0);
        check("wipe_a_gnt", {31'b0, a_gnt},     32'h0);
        check("wipe_b_gnt", {31'b0, b_gnt},     32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < D; i++) mem[i] = 32'hCAFE_0000 | i;
        ram_rdata = '0;
        rst_n = 1'b0;
        init_req = 1'b0;
        drive_a(1'b1, 1'b0, 3'd0, '0, '0);
        drive_b(1'b1, 1'b0, 3'd0, '0, '0);

        // Reset held: everything idle even with requests present.
        tick(); tick();
        check("rst_ram_req", {31'b0, ram_req},   32'h0);
        check("rst_done",    {31'b0, init_done}, 32'h0);
        check("rst_a_gnt",   {31'b0, a_gnt},     32'h0);
        check("rst_b_gnt",   {31'b0, b_gnt},     32'h0);
        check("rst_a_rv",    {31'b0, a_rvalid},  32'h0);
        check("rst_b_rv",    {31'b0, b_rvalid},  32'h0);
        drive_b(1'b0, 1'b0, 3'd0, '0, '0);

        // Release: eight wipe writes 0..7, Run on the ninth cycle.
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1 check_wipe(i);
            tick();
        end
        #1;
        check("run_done",  {31'b0, init_done}, 32'h1);
        check("run_a_gnt", {31'b0, a_gnt},     32'h1);
        tick();
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        #1;
        check("wiped0_rv",   {31'b0, a_rvalid}, 32'h1);
        check("wiped0_data", a_rdata,           32'h0);

        // a writes DEADBEEF @3 then reads it back.
        drive_a(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        #1;
        check("wr3_gnt",   {31'b0, a_gnt},     32'h1);
        check("wr3_write", {31'b0, ram_write}, 32'h1);
        check("wr3_addr",  {29'b0, ram_addr},  32'h3);
        check("wr3_wdata", ram_wdata,          32'hDEAD_BEEF);
        tick();
        drive_a(1'b1, 1'b0, 3'd3, '0, '0);
        #1;
        check("wr_no_rv",  {31'b0, a_rvalid},  32'h0);
        check("rd3_gnt",   {31'b0, a_gnt},     32'h1);
        check("rd3_write", {31'b0, ram_write}, 32'h0);
        tick();
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        #1;
        check("rd3_a_rv",  {31'b0, a_rvalid},  32'h1);
        check("rd3_data",  a_rdata,            32'hDEAD_BEEF);
        check("rd3_b_rv",  {31'b0, b_rvalid},  32'h0);
        check("idle_req",  {31'b0, ram_req},   32'h0);
        tick();
        check("rd3_pulse", {31'b0, a_rvalid},  32'h0);

        // Preload @6 by a and @5 by b, leaving the pointer favouring a.
        drive_a(1'b1, 1'b1, 3'd6, 32'h0000_AAAA, 32'hFFFF_FFFF);
        tick();
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        drive_b(1'b1, 1'b1, 3'd5, 32'h0000_BBBB, 32'hFFFF_FFFF);
        #1 check("b_wr_gnt", {31'b0, b_gnt}, 32'h1);
        tick();

        // Both read continuously: a,b,a,b with rvalid to the owner only.
        drive_a(1'b1, 1'b0, 3'd6, '0, '0);
        drive_b(1'b1, 1'b0, 3'd5, '0, '0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_a_gnt", {31'b0, a_gnt},    32'((k % 2) == 0));
            check("alt_b_gnt", {31'b0, b_gnt},    32'((k % 2) == 1));
            check("alt_req",   {31'b0, ram_req},  32'h1);
            if (k > 0) begin
                check("alt_a_rv", {31'b0, a_rvalid}, 32'((k % 2) == 1));
                check("alt_b_rv", {31'b0, b_rvalid}, 32'((k % 2) == 0));
                check("alt_data", a_rdata, ((k % 2) == 1) ? 32'h0000_AAAA : 32'h0000_BBBB);
            end
            tick();
        end
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        drive_b(1'b0, 1'b0, 3'd0, '0, '0);
        #1;
        check("alt_last_b_rv", {31'b0, b_rvalid}, 32'h1);
        check("alt_last_a_rv", {31'b0, a_rvalid}, 32'h0);
        check("alt_last_data", b_rdata,           32'h0000_BBBB);

        // b reads @5 in the same cycle as a wipe request.
        drive_b(1'b1, 1'b0, 3'd5, '0, '0);
        init_req = 1'b1;
        #1 check("ireq_b_gnt", {31'b0, b_gnt}, 32'h1);
        tick();
        init_req = 1'b0;
        drive_b(1'b0, 1'b0, 3'd0, '0, '0);
        drive_a(1'b1, 1'b0, 3'd3, '0, '0);
        #1;
        check("ireq_b_rv",   {31'b0, b_rvalid}, 32'h1);
        check("ireq_b_data", b_rdata,           32'h0000_BBBB);
        for (int i = 0; i < D; i++) begin
            #1 check_wipe(i);
            init_req = (i == 3);   // ignored mid-wipe
            tick();
        end
        init_req = 1'b0;
        #1;
        check("rewipe_done",  {31'b0, init_done}, 32'h1);
        check("rewipe_a_gnt", {31'b0, a_gnt},     32'h1);
        tick();
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        #1;
        check("rewipe_rv",   {31'b0, a_rvalid}, 32'h1);
        check("rewipe_data", a_rdata,           32'h0);

        // Partial-mask write over zero.
        drive_a(1'b1, 1'b1, 3'd3, 32'h1234_5678, 32'hFFFF_0000);
        tick();
        drive_a(1'b1, 1'b0, 3'd3, '0, '0);
        tick();
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        #1;
        check("mask_rv",   {31'b0, a_rvalid}, 32'h1);
        check("mask_data", a_rdata,           32'h1234_0000);

        // Reset mid-read: pending rvalid must be dropped.
        drive_a(1'b1, 1'b0, 3'd3, '0, '0);
        #1 check("rstrd_gnt", {31'b0, a_gnt}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rstrd_req",  {31'b0, ram_req}, 32'h0);
        check("rstrd_gnt0", {31'b0, a_gnt},   32'h0);
        tick();
        check("rstrd_rv",   {31'b0, a_rvalid}, 32'h0);
        rst_n = 1'b1;

        // Wipe restarts at 0; reset again at address 4.
        for (int i = 0; i < 4; i++) begin
            #1 check_wipe(i);
            tick();
        end
        #1 check("mid_addr4", {29'b0, ram_addr}, 32'h4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",  {31'b0, ram_req},   32'h0);
        check("mid_rst_done", {31'b0, init_done}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            #1 check_wipe(i);
            tick();
        end
        drive_a(1'b0, 1'b0, 3'd0, '0, '0);
        #1 check("final_done", {31'b0, init_done}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prim_ram_1p_arb

`default_nettype wire

// File: doc/prim_ram_1p_arb.md
PRIM_RAM_1P_ARB -- requirements
Module: prim_ram_1p_arb

Interface
REQ-001 SHALL have parameter Width, 32, RAM word width in bits.
REQ-002 SHALL have parameter Depth, 128, RAM words; localparam Aw = $clog2(Depth).
REQ-003 SHALL have port clk_i  in  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports a_req_i/b_req_i  in  1  requester access request.
REQ-006 SHALL have ports a_write_i/b_write_i  in  1  1=write, 0=read.
REQ-007 SHALL have ports a_addr_i/b_addr_i  in  Aw  word address.
REQ-008 SHALL have ports a_wdata_i/b_wdata_i, a_wmask_i/b_wmask_i  in  Width  write data and full bit mask.
REQ-009 SHALL have ports a_gnt_o/b_gnt_o  out  1  request accepted this cycle.
REQ-010 SHALL have ports a_rvalid_o/b_rvalid_o  out  1  read data valid; a_rdata_o/b_rdata_o  out  Width.
REQ-011 SHALL have RAM-side ports ram_req_o, ram_write_o (out 1), ram_addr_o (out Aw), ram_wdata_o, ram_wmask_o (out Width), ram_rdata_i (in Width; valid one cycle after a read request).
REQ-012 SHALL have ports init_req_i  in  1  request memory wipe; init_done_o  out  1  wipe complete, arbitration running.

Function
REQ-013 SHALL implement FSM states Init and Run.
REQ-014 In Init, SHALL issue one write per cycle: ram_req_o=1, ram_write_o=1, wdata=0, wmask all-ones, address counter 0..Depth-1 incrementing by 1.
REQ-015 SHALL move Init->Run in the cycle after address Depth-1 is written; init_done_o=1 only in Run.
REQ-016 In Init, a_gnt_o and b_gnt_o SHALL be 0 regardless of requests.
REQ-017 In Run, grant SHALL be combinational same-cycle: single requester is granted; both requesting -> grant the one not granted most recently (round-robin); priority pointer updates only on a grant.
REQ-018 After reset, round-robin pointer SHALL favour requester a.
REQ-019 Granted request's write/addr/wdata/wmask SHALL drive RAM ports that cycle with ram_req_o=1; no grant -> ram_req_o=0.
REQ-020 For a granted read, the owner's rvalid SHALL pulse exactly one cycle later with rdata=ram_rdata_i; writes produce no rvalid.
REQ-021 rdata outputs SHALL be ram_rdata_i (both ports); only rvalid distinguishes owner.
REQ-022 init_req_i=1 in Run SHALL move to Init next cycle, counter reset to 0; no grant in that cycle's successor; a read granted in the init_req_i cycle still returns rvalid.
REQ-023 init_req_i in Init SHALL be ignored (wipe not restarted).
REQ-024 Back-to-back grants SHALL be sustained: one access per cycle, full throughput.

Reset
REQ-025 On rst_ni low, SHALL enter Init, counter=0, pointer=a, rvalid_o=0, init_done_o=0, gnt_o=0, ram_req_o=0 during reset assertion.
REQ-026 Reset mid-wipe or mid-read SHALL abort immediately; pending rvalid is dropped; wipe restarts at address 0 on release.

Structure
REQ-027 State enum (Init, Run) SHALL live in shared package prim_ram_1p_arb_pkg.
REQ-028 The two-way round-robin SHALL be a sub-module prim_ram_1p_arb_rr (req[1:0] in, gnt[1:0] out, pointer state).
REQ-029 SHALL connect directly to prim_generic_ram_1p ports with no added latency.

Verification
REQ-030 Depth=8, reset release -> 8 zero writes addr 0..7 in consecutive cycles, init_done_o=1 on cycle 9.
REQ-031 Run, a writes 0xDEADBEEF @3, then a reads @3 -> a_rvalid_o one cycle after grant, a_rdata_o=0xDEADBEEF, b_rvalid_o=0.
REQ-032 a and b request continuously -> grants alternate a,b,a,b; each read's rvalid goes to its owner only.
REQ-033 b reads @5 while init_req_i=1 -> b_rvalid_o next cycle, then 8 wipe cycles with grants 0; subsequent read @3 returns 0.
REQ-034 rst_ni low during wipe at addr 4 -> outputs zero immediately; wipe restarts at 0 after release.
REQ-035 Partial mask write 0xFFFF0000 of 0x12345678 over 0 -> read returns 0x12340000.
